// File: rtl/pc_fetch_pkg.sv
// Shared definitions for the instruction fetch sequencer: FSM states,
// instruction widths and the default reset PC.
package pc_fetch_pkg;

  localparam int unsigned ILEN = 32;
  localparam int unsigned CLEN = 16;

  localparam logic [ILEN-1:0] START_PC_DEFAULT = 32'h8000006C;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    OUT,
    DRAIN
  } fetch_state_e;

  // Anything whose two low bits are not 2'b11 is a 16-bit instruction.
  function automatic logic is_compressed(input logic [1:0] i_lsb);
    return (i_lsb != 2'b11);
  endfunction

endpackage

// File: rtl/pc_incr.sv
// Sequential PC step: +2 after a compressed instruction, +4 otherwise,
// wrapping modulo 2^32.
module pc_incr
  import pc_fetch_pkg::*;
(
  input  logic [ILEN-1:0] i_pc,
  input  logic            i_compressed,
  output logic [ILEN-1:0] o_next_pc
);

  logic [ILEN-1:0] w_step;

  assign w_step    = i_compressed ? 32'd2 : 32'd4;
  assign o_next_pc = i_pc + w_step;

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Single-outstanding instruction fetch sequencer: requests one word, presents
// one (possibly compressed) instruction to decode, and honours redirects.
module pc_fetch_sequencer
  import pc_fetch_pkg::*;
#(
  parameter logic [ILEN-1:0] START_PC = START_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            reset_n,
  output logic            imem_req_o,
  output logic [ILEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [ILEN-1:0] imem_rdata_i,
  output logic            instr_valid_o,
  output logic [ILEN-1:0] instr_o,
  output logic [ILEN-1:0] instr_pc_o,
  output logic            instr_compressed_o,
  input  logic            instr_ready_i,
  input  logic            redirect_i,
  input  logic [ILEN-1:0] redirect_pc_i
);

  fetch_state_e    r_state;
  logic [ILEN-1:0] r_pc;
  logic [ILEN-1:0] r_target;
  logic            r_req;
  logic [ILEN-1:0] r_addr;
  logic            r_valid;
  logic [ILEN-1:0] r_instr;
  logic [ILEN-1:0] r_instr_pc;
  logic            r_comp;

  logic [ILEN-1:0] w_tgt;
  logic            w_comp;
  logic [ILEN-1:0] w_instr;
  logic [ILEN-1:0] w_next_pc;
  logic [ILEN-1:0] w_drain_tgt;

  // Redirect targets are forced to halfword alignment.
  assign w_tgt       = redirect_pc_i & ~32'h1;
  assign w_comp      = is_compressed(imem_rdata_i[1:0]);
  assign w_instr     = w_comp ? {{(ILEN-CLEN){1'b0}}, imem_rdata_i[CLEN-1:0]} : imem_rdata_i;
  assign w_drain_tgt = redirect_i ? w_tgt : r_target;

  pc_incr u_pc_incr (
    .i_pc        (r_instr_pc),
    .i_compressed(r_comp),
    .o_next_pc   (w_next_pc)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_pc       <= START_PC;
      r_target   <= '0;
      r_req      <= 1'b0;
      r_addr     <= START_PC;
      r_valid    <= 1'b0;
      r_instr    <= '0;
      r_instr_pc <= '0;
      r_comp     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_state <= REQ;
          r_req   <= 1'b1;
          if (redirect_i) begin
            r_target <= w_tgt;
            r_pc     <= w_tgt;
            r_addr   <= w_tgt;
          end else begin
            r_addr <= r_pc;
          end
        end

        REQ: begin
          if (redirect_i) begin
            r_target <= w_tgt;
            r_pc     <= w_tgt;
            // A granted request cannot be withdrawn; its data must be drained.
            if (imem_gnt_i) begin
              r_state <= DRAIN;
              r_req   <= 1'b0;
            end else begin
              r_addr <= w_tgt;
            end
          end else if (imem_gnt_i) begin
            r_state <= WAIT;
            r_req   <= 1'b0;
          end
        end

        WAIT: begin
          if (redirect_i) begin
            r_target <= w_tgt;
            r_pc     <= w_tgt;
            if (imem_rvalid_i) begin
              r_state <= REQ;
              r_req   <= 1'b1;
              r_addr  <= w_tgt;
            end else begin
              r_state <= DRAIN;
            end
          end else if (imem_rvalid_i) begin
            r_state    <= OUT;
            r_valid    <= 1'b1;
            r_instr    <= w_instr;
            r_instr_pc <= r_pc;
            r_comp     <= w_comp;
          end
        end

        OUT: begin
          if (redirect_i) begin
            r_target <= w_tgt;
            r_pc     <= w_tgt;
            r_addr   <= w_tgt;
            r_req    <= 1'b1;
            r_valid  <= 1'b0;
            r_state  <= REQ;
          end else if (instr_ready_i) begin
            r_pc    <= w_next_pc;
            r_addr  <= w_next_pc;
            r_req   <= 1'b1;
            r_valid <= 1'b0;
            r_state <= REQ;
          end
        end

        DRAIN: begin
          if (redirect_i) begin
            r_target <= w_tgt;
          end
          if (imem_rvalid_i) begin
            r_state <= REQ;
            r_req   <= 1'b1;
            r_pc    <= w_drain_tgt;
            r_addr  <= w_drain_tgt;
          end
        end

        default: begin
          r_state <= IDLE;
          r_req   <= 1'b0;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req_o         = r_req;
  assign imem_addr_o        = r_addr;
  assign instr_valid_o      = r_valid;
  assign instr_o            = r_instr;
  assign instr_pc_o         = r_instr_pc;
  assign instr_compressed_o = r_comp;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Directed bench for pc_fetch_sequencer with a transaction-level reference
// model checked every cycle plus literal expectations at key points.
module tb_pc_fetch_sequencer;

  localparam logic [31:0] START = 32'h8000006C;

  logic        clk;
  logic        reset_n;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        instr_compressed_o;
  logic        instr_ready_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;

  int n_chk  = 0;
  int n_fail = 0;

  pc_fetch_sequencer #(.START_PC(START)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .imem_req_o        (imem_req_o),
    .imem_addr_o       (imem_addr_o),
    .imem_gnt_i        (imem_gnt_i),
    .imem_rvalid_i     (imem_rvalid_i),
    .imem_rdata_i      (imem_rdata_i),
    .instr_valid_o     (instr_valid_o),
    .instr_o           (instr_o),
    .instr_pc_o        (instr_pc_o),
    .instr_compressed_o(instr_compressed_o),
    .instr_ready_i     (instr_ready_i),
    .redirect_i        (redirect_i),
    .redirect_pc_i     (redirect_pc_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks the fetch transaction in protocol terms.
  logic        m_known = 1'b0;
  logic        m_started;
  logic        m_req;
  logic [31:0] m_addr;
  logic [31:0] m_next_pc;
  logic        m_inflight;
  logic        m_dead;
  logic        m_valid;
  logic [31:0] m_instr;
  logic [31:0] m_ipc;
  logic        m_comp;

  always @(posedge clk) begin : model
    logic [31:0] t;
    t = redirect_pc_i & 32'hFFFF_FFFE;
    if (!reset_n) begin
      m_known    = 1'b1;
      m_started  = 1'b0;
      m_req      = 1'b0;
      m_addr     = START;
      m_next_pc  = START;
      m_inflight = 1'b0;
      m_dead     = 1'b0;
      m_valid    = 1'b0;
      m_instr    = 32'h0;
      m_ipc      = 32'h0;
      m_comp     = 1'b0;
    end else if (m_known) begin
      if (!m_started) begin
        m_started = 1'b1;
        if (redirect_i) m_next_pc = t;
        m_req  = 1'b1;
        m_addr = m_next_pc;
      end else if (m_req) begin
        if (imem_gnt_i) begin
          m_inflight = 1'b1;
          m_dead     = redirect_i;
          m_req      = 1'b0;
        end
        if (redirect_i) begin
          m_next_pc = t;
          if (!imem_gnt_i) m_addr = t;
        end
      end else if (m_inflight) begin
        if (imem_rvalid_i) begin
          m_inflight = 1'b0;
          if (m_dead || redirect_i) begin
            if (redirect_i) m_next_pc = t;
            m_req  = 1'b1;
            m_addr = m_next_pc;
          end else begin
            m_valid = 1'b1;
            m_comp  = (imem_rdata_i[1:0] != 2'b11);
            m_instr = m_comp ? (imem_rdata_i & 32'h0000_FFFF) : imem_rdata_i;
            m_ipc   = m_next_pc;
          end
        end else if (redirect_i) begin
          m_dead    = 1'b1;
          m_next_pc = t;
        end
      end else if (m_valid) begin
        if (redirect_i || instr_ready_i) begin
          m_valid   = 1'b0;
          m_next_pc = redirect_i ? t : (m_ipc + (m_comp ? 32'd2 : 32'd4));
          m_req     = 1'b1;
          m_addr    = m_next_pc;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_known) begin
      chk("cyc_req",   32'(imem_req_o),    32'(m_req));
      chk("cyc_addr",  imem_addr_o,        m_addr);
      chk("cyc_valid", 32'(instr_valid_o), 32'(m_valid));
      if (m_valid) begin
        chk("cyc_instr", instr_o,                 m_instr);
        chk("cyc_ipc",   instr_pc_o,              m_ipc);
        chk("cyc_comp",  32'(instr_compressed_o), 32'(m_comp));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Grant the pending request, then return data one cycle later.
  task automatic fetch_to_out(input logic [31:0] data);
    imem_gnt_i = 1'b1;
    tick();
    imem_gnt_i    = 1'b0;
    imem_rvalid_i = 1'b1;
    imem_rdata_i  = data;
    tick();
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = 32'h0;
  endtask

  task automatic accept();
    instr_ready_i = 1'b1;
    tick();
    instr_ready_i = 1'b0;
  endtask

  task automatic redirect_cycle(input logic [31:0] pc);
    redirect_i    = 1'b1;
    redirect_pc_i = pc;
    tick();
    redirect_i    = 1'b0;
    redirect_pc_i = 32'h0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n       = 1'b0;
    imem_gnt_i    = 1'b0;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = 32'h0;
    instr_ready_i = 1'b0;
    redirect_i    = 1'b0;
    redirect_pc_i = 32'h0;
    repeat (3) tick();

    chk("rst_req",   32'(imem_req_o),         32'h0);
    chk("rst_addr",  imem_addr_o,             32'h8000006C);
    chk("rst_valid", 32'(instr_valid_o),      32'h0);
    chk("rst_instr", instr_o,                 32'h0);
    chk("rst_ipc",   instr_pc_o,              32'h0);
    chk("rst_comp",  32'(instr_compressed_o), 32'h0);

    reset_n = 1'b1;
    tick();
    chk("first_req",  32'(imem_req_o), 32'h1);
    chk("first_addr", imem_addr_o,     32'h8000006C);

    fetch_to_out(32'h00000013);
    chk("s1_valid", 32'(instr_valid_o),      32'h1);
    chk("s1_instr", instr_o,                 32'h00000013);
    chk("s1_pc",    instr_pc_o,              32'h8000006C);
    chk("s1_comp",  32'(instr_compressed_o), 32'h0);
    accept();
    chk("s1_next", imem_addr_o, 32'h80000070);

    fetch_to_out(32'h00004501);
    chk("s2_instr", instr_o,                 32'h00004501);
    chk("s2_pc",    instr_pc_o,              32'h80000070);
    chk("s2_comp",  32'(instr_compressed_o), 32'h1);
    accept();
    chk("s2_next", imem_addr_o, 32'h80000072);

    fetch_to_out(32'h00A00093);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_valid", 32'(instr_valid_o), 32'h1);
      chk("hold_instr", instr_o,            32'h00A00093);
      chk("hold_pc",    instr_pc_o,         32'h80000072);
      chk("hold_req",   32'(imem_req_o),    32'h0);
    end
    accept();
    chk("hold_next", imem_addr_o, 32'h80000076);

    imem_gnt_i = 1'b1;
    tick();
    imem_gnt_i = 1'b0;
    redirect_cycle(32'h80000201);
    chk("drain_valid", 32'(instr_valid_o), 32'h0);
    imem_rvalid_i = 1'b1;
    imem_rdata_i  = 32'h00000013;
    tick();
    imem_rvalid_i = 1'b0;
    chk("redir_wait_valid", 32'(instr_valid_o), 32'h0);
    chk("redir_wait_req",   32'(imem_req_o),    32'h1);
    chk("redir_wait_addr",  imem_addr_o,        32'h80000200);

    redirect_cycle(32'hFFFFFFFC);
    chk("redir_req_addr", imem_addr_o,     32'hFFFFFFFC);
    chk("redir_req_req",  32'(imem_req_o), 32'h1);
    fetch_to_out(32'h00000013);
    accept();
    chk("wrap4_next", imem_addr_o, 32'h00000000);

    redirect_cycle(32'hFFFFFFFF);
    chk("align_addr", imem_addr_o, 32'hFFFFFFFE);
    fetch_to_out(32'hABCD0001);
    chk("wrap2_instr", instr_o, 32'h00000001);
    accept();
    chk("wrap2_next", imem_addr_o, 32'h00000000);

    fetch_to_out(32'h00000013);
    instr_ready_i = 1'b1;
    redirect_cycle(32'h80001000);
    instr_ready_i = 1'b0;
    chk("out_rdy_redir_valid", 32'(instr_valid_o), 32'h0);
    chk("out_rdy_redir_addr",  imem_addr_o,        32'h80001000);

    fetch_to_out(32'h00000013);
    redirect_cycle(32'h80002000);
    chk("out_redir_valid", 32'(instr_valid_o), 32'h0);
    chk("out_redir_addr",  imem_addr_o,        32'h80002000);

    imem_gnt_i = 1'b1;
    tick();
    imem_gnt_i    = 1'b0;
    imem_rvalid_i = 1'b1;
    imem_rdata_i  = 32'h00000013;
    redirect_cycle(32'h80003000);
    imem_rvalid_i = 1'b0;
    chk("wait_rv_redir_valid", 32'(instr_valid_o), 32'h0);
    chk("wait_rv_redir_addr",  imem_addr_o,        32'h80003000);

    imem_gnt_i = 1'b1;
    redirect_cycle(32'h80004000);
    imem_gnt_i = 1'b0;
    chk("gnt_redir_req", 32'(imem_req_o), 32'h0);
    redirect_cycle(32'h80005002);
    imem_rvalid_i = 1'b1;
    tick();
    imem_rvalid_i = 1'b0;
    chk("drain_over_addr", imem_addr_o,        32'h80005002);
    chk("drain_over_vld",  32'(instr_valid_o), 32'h0);

    imem_gnt_i = 1'b1;
    tick();
    imem_gnt_i = 1'b0;
    reset_n    = 1'b0;
    tick();
    reset_n       = 1'b1;
    imem_rvalid_i = 1'b1;
    imem_rdata_i  = 32'h00000013;
    tick();
    chk("rst_wait_valid", 32'(instr_valid_o), 32'h0);
    chk("rst_wait_req",   32'(imem_req_o),    32'h1);
    chk("rst_wait_addr",  imem_addr_o,        32'h8000006C);
    tick();
    imem_rvalid_i = 1'b0;
    chk("stale_rv_valid", 32'(instr_valid_o), 32'h0);
    fetch_to_out(32'h00004501);
    chk("rst_refetch_pc", instr_pc_o, 32'h8000006C);
    accept();
    chk("rst_refetch_next", imem_addr_o, 32'h8000006E);

    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    redirect_cycle(32'h90000000);
    chk("idle_redir_addr", imem_addr_o,     32'h90000000);
    chk("idle_redir_req",  32'(imem_req_o), 32'h1);

    repeat (2) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
